// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry, address/color widths and writer FSM encoding
package fb_pkg;
    localparam int SCREEN_W  = 320;
    localparam int SCREEN_H  = 240;
    localparam int FB_PIXELS = SCREEN_W * SCREEN_H;
    localparam int FB_ADDR_W = 17;
    localparam int COLOR_W   = 3;
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} fb_state_t;
endpackage

// File: rtl/fb_pixel_fifo.sv
// fb_pixel_fifo: synchronous FIFO of pre-computed {addr,color} pixel entries
module fb_pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = FB_ADDR_W + COLOR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: pixel-stream sink that clips, buffers and commits beats to the framebuffer
// write port, plus full-screen clear. Define FB_PIXEL_WRITER_STATS_EN for clip/stall counters.
module fb_pixel_writer
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int SCREEN_W   = fb_pkg::SCREEN_W,
    parameter int SCREEN_H   = fb_pkg::SCREEN_H
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_valid,
    input  logic [8:0]           pix_x,
    input  logic [7:0]           pix_y,
    input  logic [COLOR_W-1:0]   pix_color,
    output logic                 pix_ready,
    input  logic                 clear_start,
    input  logic [COLOR_W-1:0]   clear_color,
    output logic                 clear_busy,
    output logic                 clear_done,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [COLOR_W-1:0]   mem_data,
    output logic                 mem_we,
    input  logic                 mem_grant
`ifdef FB_PIXEL_WRITER_STATS_EN
    ,
    output logic [15:0]          clip_count,
    output logic [15:0]          stall_count
`endif
);
    localparam logic [FB_ADDR_W-1:0] CLR_END = FB_ADDR_W'(SCREEN_W * SCREEN_H);
    fb_state_t                      state, next_state;
    logic [FB_ADDR_W+COLOR_W-1:0]   fifo_dout;
    logic [FB_ADDR_W-1:0]           pix_addr, clr_addr;
    logic [COLOR_W-1:0]             clr_color;
    logic                           fifo_full, fifo_empty, clipped, accept, stage_free, load;
    assign pix_ready  = !fifo_full && state == IDLE;
    assign accept     = pix_valid && pix_ready;
    assign clipped    = 32'(pix_x) >= SCREEN_W || 32'(pix_y) >= SCREEN_H;
    assign pix_addr   = FB_ADDR_W'(pix_y) * FB_ADDR_W'(SCREEN_W) + FB_ADDR_W'(pix_x);
    assign clear_busy = state == DRAIN || state == CLEAR;
    assign clear_done = state == DONE;
    assign stage_free = !mem_we || mem_grant;
    // the clear sweep and the pixel FIFO share one output stage
    assign load       = state == CLEAR ? clr_addr != CLR_END : !fifo_empty;
    fb_pixel_fifo #(.DEPTH(FIFO_DEPTH), .W(FB_ADDR_W + COLOR_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept && !clipped),
        .din   ({pix_addr, pix_color}),
        .pop   (stage_free),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clear_start) next_state = DRAIN;
            DRAIN:   if (fifo_empty && !mem_we) next_state = CLEAR;
            CLEAR:   if (!load && stage_free) next_state = DONE;
            default: next_state = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_addr  <= '0;
            clr_color <= '0;
        end else begin
            if (state == IDLE && clear_start) clr_color <= clear_color;
            clr_addr <= state != CLEAR ? '0 : clr_addr + FB_ADDR_W'(stage_free && load);
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
        end else if (stage_free) begin
            mem_we <= load;
            if (load) {mem_addr, mem_data} <= state == CLEAR ? {clr_addr, clr_color} : fifo_dout;
        end
    end
`ifdef FB_PIXEL_WRITER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clip_count  <= '0;
            stall_count <= '0;
        end else begin
            if (accept && clipped && clip_count != 16'hFFFF) clip_count <= clip_count + 16'd1;
            if (mem_we && !mem_grant && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end
`endif
endmodule
